// File: rtl/systolic_pkg.sv
// Shared constants, loader state encoding and operand byte-offset helpers.
// Latency: none (package). Backpressure: n/a.
// Used by the operand loader top and its byte bank.
package systolic_pkg;

    localparam int DATA_W     = 8;
    localparam int N_FILT     = 9;
    localparam int N_IN       = 16;
    localparam int FRAME_LEN  = 25;
    localparam int RUN_CYCLES = 34;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } loader_state_t;

    // Flat-bus byte offsets: filter is 3 wide, input matrix is 4 wide.
    function automatic int f_off(input int row, input int col);
        return 3 * row + col;
    endfunction

    function automatic int i_off(input int row, input int col);
        return 4 * row + col;
    endfunction

endpackage

// File: rtl/loader_byte_bank.sv
// Write-enabled operand register bank; entries 0..N_FILT-1 are filter bytes, the rest input bytes.
// Latency: write visible on the bus one cycle after wr_en. Backpressure: none, always accepts writes.
// Unwritten entries hold their value; synchronous reset clears all entries.
module loader_byte_bank
    import systolic_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int N_FILT = 9,
    parameter int N_IN   = 16,
    parameter int IDX_W  = 5
) (
    input  logic                     clk_in,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [IDX_W-1:0]         wr_idx,
    input  logic [DATA_W-1:0]        wr_dat,
    output logic [N_FILT*DATA_W-1:0] f_flat,
    output logic [N_IN*DATA_W-1:0]   i_flat
);

    localparam int N_ENT = N_FILT + N_IN;

    logic [DATA_W-1:0] mem [N_ENT];

    always_ff @(posedge clk_in) begin
        if (rst) begin
            for (int k = 0; k < N_ENT; k++) mem[k] <= '0;
        end else begin
            for (int k = 0; k < N_ENT; k++) begin
                if (wr_en && (wr_idx == IDX_W'(k))) mem[k] <= wr_dat;
            end
        end
    end

    for (genvar g = 0; g < N_FILT; g++) begin : g_filt
        assign f_flat[g*DATA_W +: DATA_W] = mem[g];
    end

    for (genvar g = 0; g < N_IN; g++) begin : g_in
        assign i_flat[g*DATA_W +: DATA_W] = mem[N_FILT + g];
    end

endmodule

// File: rtl/systolic_operand_loader.sv
// Byte-serial framed loader for the 3x3 systolic array; holds the array in reset while loading, then runs it.
// Latency: res_valid rises RUN_CYCLES cycles after the final-byte edge. Backpressure: s_ready low outside LOAD.
// Optional SYSTOLIC_LOADER_FILTER_REUSE_EN adds reuse_filt for input-only follow-up frames.
module systolic_operand_loader
    import systolic_pkg::*;
#(
    parameter int DATA_W     = systolic_pkg::DATA_W,
    parameter int N_FILT     = systolic_pkg::N_FILT,
    parameter int N_IN       = systolic_pkg::N_IN,
    parameter int RUN_CYCLES = systolic_pkg::RUN_CYCLES
) (
    input  logic                     clk_in,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        s_data,
    input  logic                     s_valid,
    input  logic                     s_last,
    output logic                     s_ready,
    output logic [N_FILT*DATA_W-1:0] f_flat,
    output logic [N_IN*DATA_W-1:0]   i_flat,
    output logic                     arr_rst,
    output logic                     busy,
    output logic                     res_valid,
    input  logic                     res_ack,
`ifdef SYSTOLIC_LOADER_FILTER_REUSE_EN
    input  logic                     reuse_filt,
`endif
    output logic                     err
);

    localparam int LAST_IDX = N_FILT + N_IN - 1;
    localparam int IDX_W    = $clog2(N_FILT + N_IN);
    localparam int RUN_W    = $clog2(RUN_CYCLES + 1);

    loader_state_t     state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [RUN_W-1:0]  run_cnt_q, run_cnt_d;
    logic              err_q, err_d;
    logic              wr_en;
    logic              xfer;

    assign s_ready   = (state_q == LOAD) && !rst;
    assign arr_rst   = rst || (state_q == LOAD);
    assign busy      = (state_q == RUN);
    assign res_valid = (state_q == DONE);
    assign err       = err_q;
    assign xfer      = s_valid && s_ready;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        run_cnt_d = run_cnt_q;
        err_d     = 1'b0;
        wr_en     = 1'b0;
        unique case (state_q)
            LOAD: begin
                if (xfer) begin
                    // s_last must coincide exactly with the final frame position.
                    if (s_last != (idx_q == IDX_W'(LAST_IDX))) begin
                        err_d = 1'b1;
                        idx_d = '0;
                    end else begin
                        wr_en = 1'b1;
                        if (s_last) begin
                            idx_d   = '0;
                            state_d = RUN;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
            end
            RUN: begin
                if (run_cnt_q == RUN_W'(RUN_CYCLES - 1)) begin
                    run_cnt_d = '0;
                    state_d   = DONE;
                end else begin
                    run_cnt_d = run_cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (res_ack) begin
                    state_d = LOAD;
`ifdef SYSTOLIC_LOADER_FILTER_REUSE_EN
                    idx_d = reuse_filt ? IDX_W'(N_FILT) : '0;
`else
                    idx_d = '0;
`endif
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q   <= LOAD;
            idx_q     <= '0;
            run_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            run_cnt_q <= run_cnt_d;
            err_q     <= err_d;
        end
    end

    loader_byte_bank #(
        .DATA_W (DATA_W),
        .N_FILT (N_FILT),
        .N_IN   (N_IN),
        .IDX_W  (IDX_W)
    ) u_bank (
        .clk_in (clk_in),
        .rst    (rst),
        .wr_en  (wr_en),
        .wr_idx (idx_q),
        .wr_dat (s_data),
        .f_flat (f_flat),
        .i_flat (i_flat)
    );

endmodule

// File: tb/tb_systolic_operand_loader.sv
// Directed bench for systolic_operand_loader: frame-level model checked every cycle,
// plus literal expectations for timing, packing and convolution results.
module tb_systolic_operand_loader;
    import systolic_pkg::*;

    logic         clk_in = 1'b0;
    logic         rst;
    logic [7:0]   s_data;
    logic         s_valid, s_last, res_ack;
    logic         s_ready, arr_rst, busy, res_valid, err;
    logic [71:0]  f_flat;
    logic [127:0] i_flat;

    always #5 clk_in = ~clk_in;

    systolic_operand_loader dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_last    (s_last),
        .s_ready   (s_ready),
        .f_flat    (f_flat),
        .i_flat    (i_flat),
        .arr_rst   (arr_rst),
        .busy      (busy),
        .res_valid (res_valid),
        .res_ack   (res_ack),
`ifdef SYSTOLIC_LOADER_FILTER_REUSE_EN
        .reuse_filt(1'b0),
`endif
        .err       (err)
    );

    int vectors = 0;
    int miscompares = 0;
    int err_seen = 0;
    int cyc = 0;
    bit cmp_en = 0;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Frame-level model: bytes received so far, countdown of the run window, results pending.
    logic [7:0] m_f [9];
    logic [7:0] m_i [16];
    int  m_cnt, m_run_left;
    bit  m_done, m_err;

    always @(posedge clk_in) begin
        cyc++;
        if (rst) begin
            m_cnt = 0; m_run_left = 0; m_done = 0; m_err = 0;
            for (int k = 0; k < 9; k++) m_f[k] = 8'h00;
            for (int k = 0; k < 16; k++) m_i[k] = 8'h00;
        end else begin
            m_err = 0;
            if (m_run_left > 0) begin
                m_run_left--;
                if (m_run_left == 0) m_done = 1;
            end else if (m_done) begin
                if (res_ack) m_done = 0;
            end else if (s_valid) begin
                if (s_last != (m_cnt == 24)) begin
                    m_err = 1;
                    m_cnt = 0;
                end else begin
                    if (m_cnt < 9) m_f[m_cnt] = s_data;
                    else m_i[m_cnt-9] = s_data;
                    if (m_cnt == 24) begin
                        m_cnt = 0;
                        m_run_left = 34;
                    end else begin
                        m_cnt++;
                    end
                end
            end
        end
        cmp_en = 1;
    end

    always @(negedge clk_in) begin
        if (cmp_en) begin
            logic [71:0]  ef;
            logic [127:0] ei;
            bit loading;
            for (int k = 0; k < 9; k++) ef[k*8 +: 8] = m_f[k];
            for (int k = 0; k < 16; k++) ei[k*8 +: 8] = m_i[k];
            loading = (m_run_left == 0) && !m_done;
            check("s_ready",   s_ready,   !rst && loading);
            check("arr_rst",   arr_rst,   rst || loading);
            check("busy",      busy,      m_run_left > 0);
            check("res_valid", res_valid, m_done);
            check("err",       err,       m_err);
            check("f_flat",    f_flat,    ef);
            check("i_flat",    i_flat,    ei);
            if (err) err_seen++;
        end
    end

    logic [7:0] frm [25];

    task automatic build(input int mode);
        for (int k = 0; k < 25; k++) begin
            case (mode)
                0: frm[k] = (k < 9) ? 8'd1 : 8'(k - 9);
                1: frm[k] = 8'(k + 100);
                default: frm[k] = (k < 9) ? 8'd2 : 8'(15 - (k - 9));
            endcase
        end
    endtask

    task automatic send_frame(input int n, input int last_at, input bit throttle, output int ncyc);
        int c0;
        bit rdy;
        int t;
        @(posedge clk_in); #1;
        c0 = cyc;
        for (int k = 0; k < n; k++) begin
            s_valid = 1'b1;
            s_data  = frm[k];
            s_last  = (k == last_at);
            t = 0;
            do begin
                @(negedge clk_in);
                rdy = s_ready;
                @(posedge clk_in); #1;
                t++;
            end while (!rdy && t < 200);
            if (!rdy) check("send_timeout", 0, 1);
            if (throttle) begin
                s_valid = 1'b0;
                s_last  = 1'b0;
                @(posedge clk_in); #1;
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        ncyc = cyc - c0;
    endtask

    task automatic wait_rv(output int n);
        n = 0;
        while (n < 200) begin
            @(negedge clk_in);
            if (res_valid) break;
            n++;
        end
        if (n >= 200) check("res_valid_timeout", 0, 1);
    endtask

    task automatic do_ack();
        res_ack = 1'b1;
        @(posedge clk_in); #1;
        res_ack = 1'b0;
    endtask

    function automatic int conv(input int r, input int c);
        int s = 0;
        for (int a = 0; a < 3; a++)
            for (int b = 0; b < 3; b++)
                s += int'(f_flat[f_off(a, b)*8 +: 8]) * int'(i_flat[i_off(r + a, c + b)*8 +: 8]);
        return s;
    endfunction

    initial begin
        int n, nc, e0;
        logic [71:0]  nf;
        logic [127:0] ni;
        rst = 1'b1; s_data = '0; s_valid = 0; s_last = 0; res_ack = 0;
        repeat (3) @(posedge clk_in);
        #1;
        check("rst_s_ready", s_ready, 0);
        check("rst_arr_rst", arr_rst, 1);
        check("rst_f_flat",  f_flat, 0);
        check("rst_busy",    busy, 0);
        rst = 1'b0;
        @(negedge clk_in);
        check("post_rst_s_ready", s_ready, 1);

        // Nominal frame
        build(0);
        e0 = err_seen;
        send_frame(25, 24, 0, nc);
        wait_rv(n);
        check("run_window", n, 34);
        check("o00", conv(0, 0), 45);
        check("o01", conv(0, 1), 54);
        check("o10", conv(1, 0), 81);
        check("o11", conv(1, 1), 90);
        check("f_pack", f_flat, {9{8'h01}});
        check("i_pack_b7", i_flat[7*8 +: 8], 7);
        check("i_pack_b15", i_flat[15*8 +: 8], 15);
        nf = f_flat; ni = i_flat;
        do_ack();

        // Throttled stream
        send_frame(25, 24, 1, nc);
        check("throttle_cycles", nc, 50);
        wait_rv(n);
        check("throttle_f", f_flat, nf);
        check("throttle_i", i_flat, ni);
        check("throttle_no_err", err_seen, e0);
        do_ack();

        // Early s_last, then a good frame
        build(1);
        send_frame(6, 5, 0, nc);
        @(negedge clk_in);
        check("early_err", err, 1);
        check("early_arr_rst", arr_rst, 1);
        build(2);
        send_frame(25, 24, 0, nc);
        wait_rv(n);
        check("recover_window", n, 34);
        check("recover_o00", conv(0, 0), 180);
        check("early_err_count", err_seen, e0 + 1);
        do_ack();

        // Missing s_last
        build(0);
        send_frame(25, -1, 0, nc);
        @(negedge clk_in);
        check("missing_err", err, 1);
        repeat (5) @(negedge clk_in);
        check("missing_arr_rst", arr_rst, 1);
        check("missing_busy", busy, 0);
        check("missing_err_count", err_seen, e0 + 2);

        // Back-pressure and ack
        send_frame(25, 24, 0, nc);
        s_valid = 1'b1; s_data = 8'hAA;
        repeat (5) @(posedge clk_in);
        #1;
        do_ack();
        @(negedge clk_in);
        check("run_s_ready", s_ready, 0);
        check("run_ack_ignored", busy, 1);
        wait_rv(n);
        repeat (5) @(negedge clk_in);
        check("done_hold", res_valid, 1);
        check("done_s_ready", s_ready, 0);
        s_valid = 1'b0;
        do_ack();
        @(negedge clk_in);
        check("ack_s_ready", s_ready, 1);
        check("ack_arr_rst", arr_rst, 1);
        check("ack_res_valid", res_valid, 0);

        // Reset mid-run
        send_frame(25, 24, 0, nc);
        repeat (10) @(posedge clk_in);
        #1;
        rst = 1'b1;
        @(negedge clk_in);
        check("rst_hi_s_ready", s_ready, 0);
        check("rst_hi_arr_rst", arr_rst, 1);
        @(posedge clk_in); #1;
        @(negedge clk_in);
        check("midrun_busy", busy, 0);
        check("midrun_f", f_flat, 0);
        check("midrun_i", i_flat, 0);
        rst = 1'b0;
        @(negedge clk_in);
        check("midrun_s_ready", s_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/systolic_operand_loader.md
Name: systolic_operand_loader

Overview:
- Byte-serial front end for the 3x3 systolic convolution array (4x4 input, 3x3 filter, 2x2 result).
- Accepts a framed valid/ready byte stream and assembles it into the parallel i00..i33 / f00..f22 operand buses.
- Holds the array in reset while loading, then releases it for a fixed run window.
- Raises res_valid once the array's o00..o11 are settled, and waits for res_ack before accepting the next frame.

Parameters:
- DATA_W, 8, operand byte width.
- N_FILT, 9, filter bytes per frame.
- N_IN, 16, input-matrix bytes per frame.
- RUN_CYCLES, 34, cycles arr_rst is held low before res_valid asserts; covers the array counter reaching 32 plus the o11 load edge.

Ports:
- clk_in  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- s_data  in  DATA_W  stream byte.
- s_valid  in  1  s_data valid.
- s_last  in  1  final byte of frame.
- s_ready  out  1  loader accepts a byte this cycle.
- f_flat  out  N_FILT*DATA_W  filter bus; byte k = f(row,col), k=3*row+col.
- i_flat  out  N_IN*DATA_W  input bus; byte k = i(row,col), k=4*row+col.
- arr_rst  out  1  reset to the systolic array.
- busy  out  1  array run window active.
- res_valid  out  1  array outputs stable and readable.
- res_ack  in  1  consumer has read results.
- err  out  1  one-cycle pulse on a framing error.

Behaviour:
- Clock and reset: one clock, clk_in; reset rst is synchronous and active-high.
- Reset state:
  - state=LOAD, idx=0, run_cnt=0, f_flat=0, i_flat=0.
  - busy=0, res_valid=0, err=0.
  - s_ready=0 while rst is high; arr_rst=1 while rst is high.
- Transfer rule: a byte transfers on a rising edge with s_valid&s_ready. No transfer otherwise; idx holds.
- Frame order: 9 filter bytes f00,f01,f02,f10..f22, then 16 input bytes i00..i33, row-major. Total 25 bytes; idx runs 0..24.
- Byte write: idx<9 writes f_flat byte idx; idx>=9 writes i_flat byte idx-9. All other bytes hold their value.
- State LOAD:
  - s_ready=1, arr_rst=1, busy=0, res_valid=0.
  - Transfer with idx<24 and s_last=0: write byte, idx++.
  - Transfer with idx<24 and s_last=1 (early last): err pulses, byte discarded, idx<=0. Bytes already written stay but are overwritten by the next frame.
  - Transfer with idx==24 and s_last=1: write byte, idx<=0, go to RUN.
  - Transfer with idx==24 and s_last=0: err pulses, byte discarded, idx<=0, stay in LOAD.
- State RUN:
  - s_ready=0, arr_rst=0, busy=1.
  - run_cnt increments every cycle from 0. When run_cnt==RUN_CYCLES-1: run_cnt<=0, go to DONE.
  - arr_rst first goes low in the cycle after the final-byte edge.
  - res_valid rises exactly RUN_CYCLES cycles after that edge.
- State DONE:
  - s_ready=0, arr_rst=0, busy=0, res_valid=1.
  - Operand buses hold, so array outputs stay valid.
  - res_ack=1: go to LOAD next edge; arr_rst reasserts, which clears the array's results.
- Ignored events:
  - res_ack in LOAD or RUN is ignored.
  - s_valid in RUN or DONE is ignored; the producer must hold the byte.
- err: registered, high exactly one cycle per error.
- rst mid-frame or mid-run: returns to reset state next edge; partial frame is lost.

Optional Feature:
- Macro: SYSTOLIC_LOADER_FILTER_REUSE_EN.
- With the macro defined:
  - Adds input port reuse_filt (1 bit), sampled on the DONE-state edge where res_ack=1.
  - If reuse_filt=1, the next frame is 16 input bytes only: idx starts at 9, f_flat is retained, s_last is expected at idx 24.
  - reuse_filt is ignored on the first frame after rst, which is always 25 bytes.
- Without the macro: no reuse_filt port; every frame is 25 bytes.

Decomposition:
- Shared package/include systolic_pkg holds:
  - DATA_W, N_FILT, N_IN, FRAME_LEN=25, RUN_CYCLES default.
  - Loader state encoding: LOAD=2'd0, RUN=2'd1, DONE=2'd2.
  - Byte-index helpers mapping (row,col) to flat-bus offset.
- One sub-module: loader_byte_bank.
  - A 25-entry, DATA_W-wide write-enabled register bank with index decode.
  - Exposes the flattened f_flat/i_flat buses.
  - Instantiated once; control FSM and run counter stay in the top.

Test Plan:
- Nominal frame:
  - Stimulus: filter all 1, input i(r,c)=4r+c, s_valid held high, then await res_valid.
  - Response: arr_rst low 34 cycles; array o00=45, o01=54, o10=81, o11=90.
  - Response: res_valid=1; f_flat/i_flat match packing.
- Throttled stream:
  - Stimulus: s_valid toggled 1/0 every cycle.
  - Response: 25 transfers in 50 cycles, identical buses to the nominal case, no err.
- Early s_last:
  - Stimulus: s_last at byte 5.
  - Response: err one cycle, idx=0, stay in LOAD. A following good 25-byte frame completes normally.
- Missing s_last:
  - Stimulus: byte 24 sent with s_last=0.
  - Response: err pulse, no RUN, arr_rst stays 1.
- Back-pressure and ack:
  - Stimulus: s_valid high in RUN/DONE, res_ack pulsed during RUN, then res_ack in DONE.
  - Response: s_ready=0 throughout RUN/DONE; the RUN-time res_ack is ignored; LOAD is re-entered only on the DONE ack.
- Reset mid-run:
  - Stimulus: rst at run_cnt=10.
  - Response: next cycle all outputs at reset values, arr_rst=1, s_ready=1 after rst drops.
